// File: rtl/raster_span_scanner.sv
// Triangle span scanner: walks a clamped bounding box in LANES-wide spans, row by row,
// emitting a coverage mask and the three edge-function values of every lane.
module raster_span_scanner #(
   parameter int COORD_W    = 32,
   parameter int COEFF_W    = 16,
   parameter int ACC_W      = 48,
   parameter int LANES      = 4,
   parameter int SCREEN_W   = 1024,
   parameter int SCREEN_H   = 1024,
   parameter int SKIP_EMPTY = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_in_valid,
   output logic                       o_in_ready,
   input  logic [COEFF_W-1:0]         i_a0,
   input  logic [COEFF_W-1:0]         i_a1,
   input  logic [COEFF_W-1:0]         i_a2,
   input  logic [COEFF_W-1:0]         i_b0,
   input  logic [COEFF_W-1:0]         i_b1,
   input  logic [COEFF_W-1:0]         i_b2,
   input  logic [ACC_W-1:0]           i_c0,
   input  logic [ACC_W-1:0]           i_c1,
   input  logic [ACC_W-1:0]           i_c2,
   input  logic [COORD_W-1:0]         i_min_x,
   input  logic [COORD_W-1:0]         i_min_y,
   input  logic [COORD_W-1:0]         i_max_x,
   input  logic [COORD_W-1:0]         i_max_y,
   output logic                       o_out_valid,
   input  logic                       i_out_ready,
   output logic [COORD_W-1:0]         o_frag_x,
   output logic [COORD_W-1:0]         o_frag_y,
   output logic [LANES-1:0]           o_mask,
   output logic [3*LANES*ACC_W-1:0]   o_edge_val,
   output logic                       o_last,
   output logic                       o_tri_done
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_DONE} state_t;

   localparam logic [COORD_W-1:0] XLIM = COORD_W'(SCREEN_W - 1);
   localparam logic [COORD_W-1:0] YLIM = COORD_W'(SCREEN_H - 1);

   // Product mod 2^ACC_W of a signed coefficient and an unsigned coordinate.
   function automatic logic [ACC_W-1:0] f_mul(input logic [COEFF_W-1:0] a,
                                               input logic [COORD_W-1:0] x);
      logic [ACC_W-1:0] ae;
      logic [ACC_W-1:0] xe;
      ae = ACC_W'($signed(a));
      xe = ACC_W'(x);
      return ae * xe;
   endfunction

   state_t                              r_state;
   logic                                r_in_ready;
   logic                                r_tri_done;
   logic [2:0][COEFF_W-1:0]             r_a;
   logic [2:0][COEFF_W-1:0]             r_b;
   logic [2:0][ACC_W-1:0]               r_c;
   logic [2:0][ACC_W-1:0]               r_step;
   logic [COORD_W-1:0]                  r_min_x, r_min_y, r_max_x, r_max_y;
   logic [COORD_W-1:0]                  r_cx, r_cy;
   logic [LANES-1:0][2:0][ACC_W-1:0]    r_row_e;
   logic [LANES-1:0][2:0][ACC_W-1:0]    r_lane_e;

   logic [LANES-1:0][2:0][ACC_W-1:0]    w_start;
   logic [LANES-1:0]                    w_cov;
   logic [COORD_W:0]                    w_xend;
   logic                                w_row_end;
   logic                                w_last_span;
   logic                                w_scan;
   logic                                w_emit;
   logic                                w_adv;
   logic                                w_degen;

   assign w_scan      = (r_state == S_SCAN);
   assign w_xend      = {1'b0, r_cx} + (COORD_W+1)'(LANES);
   assign w_row_end   = w_xend > {1'b0, r_max_x};
   assign w_last_span = w_row_end && (r_cy == r_max_y);
   assign w_degen     = (r_min_x > r_max_x) || (r_min_y > r_max_y);
   assign w_emit      = (w_cov != '0) || w_last_span || (SKIP_EMPTY == 0);
   // Empty spans are not presented, so they advance without waiting on out_ready.
   assign w_adv       = w_scan && (w_emit ? i_out_ready : 1'b1);

   always_comb begin
      w_cov = '0;
      for (int i = 0; i < LANES; i++)
         w_cov[i] = !r_lane_e[i][0][ACC_W-1] && !r_lane_e[i][1][ACC_W-1] &&
                    !r_lane_e[i][2][ACC_W-1] &&
                    (({1'b0, r_cx} + (COORD_W+1)'(i)) <= {1'b0, r_max_x});
   end

   always_comb begin
      w_start = '0;
      for (int i = 0; i < LANES; i++)
         for (int j = 0; j < 3; j++)
            w_start[i][j] = f_mul(r_a[j], r_min_x) + f_mul(r_a[j], COORD_W'(i)) +
                            f_mul(r_b[j], r_min_y) + r_c[j];
   end

   assign o_in_ready  = r_in_ready;
   assign o_tri_done  = r_tri_done;
   assign o_out_valid = w_scan && w_emit;
   assign o_mask      = w_scan ? w_cov : '0;
   assign o_last      = w_scan && w_last_span;
   assign o_frag_x    = r_cx;
   assign o_frag_y    = r_cy;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      for (genvar gj = 0; gj < 3; gj++) begin : g_edge
         assign o_edge_val[(3*gi+gj)*ACC_W +: ACC_W] = r_lane_e[gi][gj];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b1;
         r_tri_done <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_c        <= '0;
         r_step     <= '0;
         r_min_x    <= '0;
         r_min_y    <= '0;
         r_max_x    <= '0;
         r_max_y    <= '0;
         r_cx       <= '0;
         r_cy       <= '0;
         r_row_e    <= '0;
         r_lane_e   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_in_valid) begin
                  r_a        <= {i_a2, i_a1, i_a0};
                  r_b        <= {i_b2, i_b1, i_b0};
                  r_c        <= {i_c2, i_c1, i_c0};
                  r_min_x    <= i_min_x;
                  r_min_y    <= i_min_y;
                  r_max_x    <= (i_max_x > XLIM) ? XLIM : i_max_x;
                  r_max_y    <= (i_max_y > YLIM) ? YLIM : i_max_y;
                  r_in_ready <= 1'b0;
                  r_state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_degen) begin
                  r_tri_done <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_row_e  <= w_start;
                  r_lane_e <= w_start;
                  r_cx     <= r_min_x;
                  r_cy     <= r_min_y;
                  for (int j = 0; j < 3; j++)
                     r_step[j] <= f_mul(r_a[j], COORD_W'(LANES));
                  r_state  <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_adv) begin
                  if (w_last_span) begin
                     r_tri_done <= 1'b1;
                     r_state    <= S_DONE;
                  end else if (w_row_end) begin
                     r_cx <= r_min_x;
                     r_cy <= r_cy + 1'b1;
                     for (int i = 0; i < LANES; i++)
                        for (int j = 0; j < 3; j++) begin
                           r_row_e[i][j]  <= r_row_e[i][j] + ACC_W'($signed(r_b[j]));
                           r_lane_e[i][j] <= r_row_e[i][j] + ACC_W'($signed(r_b[j]));
                        end
                  end else begin
                     r_cx <= r_cx + COORD_W'(LANES);
                     for (int i = 0; i < LANES; i++)
                        for (int j = 0; j < 3; j++)
                           r_lane_e[i][j] <= r_lane_e[i][j] + r_step[j];
                  end
               end
            end
            S_DONE: begin
               r_tri_done <= 1'b0;
               r_in_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
